// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset core.
// Contents: opcode/funct encodings, FSM state encoding, ALU operation codes,
// and small decode helpers used by the top-level control logic.
package mc_pkg;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    // Unknown functs never reach the ALU result (they trap in EXEC),
    // so falling back to ADD is harmless.
    function automatic alu_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
        case (opcode)
            OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                             (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file for the multicycle core.
// Ports: clk/rst (async active-high clear of all registers), two
// asynchronous read ports (raddr_a/rdata_a, raddr_b/rdata_b) and one
// synchronous write port (we, waddr, wdata). Register 0 always reads zero
// and writes to it are dropped.
module mc_regfile #(
    parameter int NREGS  = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] raddr_a,
    input  logic [RIDX_W-1:0] raddr_b,
    output logic [31:0]       rdata_a,
    output logic [31:0]       rdata_b,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [31:0]       wdata
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? 32'h0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? 32'h0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: one shared ALU, one unified word-addressed
// memory port, sequenced by a six-state FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports: clk, rst (async active-high); memory port mem_req/mem_we/mem_addr/
// mem_wdata/mem_rdata/mem_ready; status halted/illegal; debug pc_out and
// state_out (raw FSM encoding).
//
// Memory handshake: mem_req is decoded from the registered state only (plus
// rst so a reset drops it at once). While mem_req=1, mem_addr/mem_we/mem_wdata
// come from registers that do not change until the cycle in which
// mem_ready=1; that cycle completes the transfer and mem_rdata is sampled on
// its closing edge. Ready in the first request cycle is allowed.
module multicycle_datapath
    import mc_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [31:0]       pc_out,
    output logic [2:0]        state_out
);

    localparam int RIDX_W = (NREGS > 2) ? $clog2(NREGS) : 1;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
    logic        illegal_q;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] sext_imm;
    logic        legal;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign imm26    = ir_q[25:0];
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign legal    = is_legal(opcode, funct);

    // Register file
    logic [31:0]       rf_a, rf_b, rf_wdata;
    logic [RIDX_W-1:0] rf_waddr;
    logic              rf_we;

    assign rf_we    = (state_q == S_WB);
    assign rf_waddr = (opcode == OP_RTYPE) ? ir_q[11+:RIDX_W] : ir_q[16+:RIDX_W];
    assign rf_wdata = (opcode == OP_LW) ? mdr_q : alu_out_q;

    mc_regfile #(.NREGS(NREGS), .RIDX_W(RIDX_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ir_q[21+:RIDX_W]),
        .raddr_b (ir_q[16+:RIDX_W]),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // Shared ALU: computes the branch target in DECODE, the instruction
    // result / effective address in EXEC.
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_t     alu_op;

    always_comb begin
        alu_a  = a_q;
        alu_b  = sext_imm;
        alu_op = ALU_ADD;
        if (state_q == S_DECODE) begin
            alu_a = pc_q;
            alu_b = {sext_imm[29:0], 2'b00};
        end else if (opcode == OP_RTYPE) begin
            alu_b  = b_q;
            alu_op = funct_to_op(funct);
        end
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!legal) begin
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: state_d = S_WB;
                        OP_LW, OP_SW:      state_d = S_MEM;
                        OP_HALT:           state_d = S_HALT;
                        default:           state_d = S_FETCH;  // beq, j
                    endcase
                end
            end
            S_MEM:    if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_q       <= rf_a;
                    b_q       <= rf_b;
                    alu_out_q <= alu_y;
                end
                S_EXEC: begin
                    if (!legal) begin
                        illegal_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: alu_out_q <= alu_y;
                            OP_BEQ: if (a_q == b_q) pc_q <= alu_out_q;
                            OP_J:   pc_q <= {pc_q[31:28], imm26, 2'b00};
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    if (mem_ready && (opcode == OP_LW)) mdr_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    assign mem_req   = !rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = !rst && (state_q == S_MEM) && (opcode == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? alu_out_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign pc_out    = pc_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed testbench for multicycle_datapath: word-addressed memory model
// with programmable wait states, hand-computed expectations checked with
// immediate assertions.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        halted, illegal;
    logic [31:0] pc_out;
    logic [2:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    int          wait_cycles = 0;
    int          wait_cnt;

    always #5 clk = ~clk;

    multicycle_datapath #(.ADDR_W(8), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .illegal   (illegal),
        .pc_out    (pc_out),
        .state_out (state_out)
    );

    // Memory model: ready after wait_cycles stalled request cycles.
    assign mem_ready = mem_req && (wait_cnt == wait_cycles);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (mem_req && mem_ready)  wait_cnt <= 0;
        else if (mem_req)               wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
    end

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    localparam logic [31:0] HALT_W = {6'h3F, 26'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enter_reset(input int waits);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles = waits;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog1();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);   // addi $1,$0,5
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);   // addi $2,$0,7
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);    // add  $3,$1,$2
        mem[3] = HALT_W;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and basic program, zero-wait memory
        enter_reset(0);
        load_prog1();
        step(1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_state", state_out, 3'd0);
        leave_reset();
        step(14);
        chk("p1_state_14", state_out, 3'd2);
        chk("p1_halted_14", halted, 0);
        step(1);
        chk("p1_halted_15", halted, 1);
        chk("p1_illegal", illegal, 0);
        chk("p1_r3", dut.u_regfile.regs[3], 32'd12);
        chk("p1_pc", pc_out, 32'd16);
        step(3);
        chk("p1_halt_req", mem_req, 0);

        // 2: sw then lw
        enter_reset(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);  // addi $3,$0,12
        mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd16);  // sw $3,16($0)
        mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd16);  // lw $4,16($0)
        mem[3] = HALT_W;
        leave_reset();
        step(8);
        chk("sw_mem4", mem[4], 32'd12);
        chk("sw_state", state_out, 3'd0);
        step(4);
        chk("lw_state_wb", state_out, 3'd4);
        step(1);
        chk("lw_state_fetch", state_out, 3'd0);
        chk("lw_r4", dut.u_regfile.regs[4], 32'd12);
        chk("lw_pc", pc_out, 32'd12);

        // 3: three wait states on every access
        enter_reset(3);
        load_prog1();
        leave_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("w_fetch_state", state_out, 3'd0);
            chk("w_fetch_req", mem_req, 1);
            chk("w_fetch_addr", mem_addr, 8'd0);
        end
        step(4);
        chk("w_i1_state", state_out, 3'd0);
        chk("w_i1_addr", mem_addr, 8'd1);
        chk("w_i1_pc", pc_out, 32'd4);
        step(19);
        chk("w_halted_26", halted, 0);
        step(1);
        chk("w_halted_27", halted, 1);
        chk("w_r3", dut.u_regfile.regs[3], 32'd12);

        // 4a: beq taken, target = 12 + (-2<<2) = 4
        enter_reset(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE);
        leave_reset();
        step(11);
        chk("beq_taken_pc", pc_out, 32'd4);
        chk("beq_taken_state", state_out, 3'd0);

        // 4b: beq not taken
        enter_reset(0);
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
        leave_reset();
        step(11);
        chk("beq_nt_pc", pc_out, 32'd12);

        // 4c: j 0x40
        enter_reset(0);
        mem[0] = {6'h02, 26'h40};
        leave_reset();
        step(3);
        chk("j_pc", pc_out, 32'h100);
        chk("j_addr", mem_addr, 8'h40);

        // 5a: illegal opcode 0x3E
        enter_reset(0);
        mem[0] = {6'h3E, 26'h0};
        leave_reset();
        step(1);
        chk("ill_decode", state_out, 3'd1);
        step(1);
        chk("ill_halted_early", halted, 0);
        step(1);
        chk("ill_halted", halted, 1);
        chk("ill_flag", illegal, 1);
        step(4);
        chk("ill_req", mem_req, 0);

        // 5b: unknown funct under opcode 0
        enter_reset(0);
        mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
        leave_reset();
        step(3);
        chk("fn_halted", halted, 1);
        chk("fn_illegal", illegal, 1);

        // 6: reset during sw memory wait
        enter_reset(3);
        mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd7);   // addi $3,$0,7
        mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'd20);  // sw $3,20($0)
        leave_reset();
        step(14);
        chk("rs_state_mem", state_out, 3'd3);
        chk("rs_we", mem_we, 1);
        chk("rs_addr", mem_addr, 8'd5);
        rst = 1'b1;
        #1;
        chk("rs_req_drop", mem_req, 0);
        chk("rs_pc", pc_out, 32'h0);
        step(2);
        chk("rs_no_write", mem[5], 32'h0);
        wait_cycles = 0;
        mem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);   // addi $0,$0,9
        mem[1] = enc_i(6'h2B, 5'd0, 5'd0, 16'd24);  // sw $0,24($0)
        mem[2] = HALT_W;
        mem[6] = 32'hDEAD_BEEF;
        leave_reset();
        step(11);
        chk("r0_zero", mem[6], 32'h0);
        chk("r0_halted", halted, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
